// File: rtl/semimips_pkg.sv
// Shared definitions for the semimips EX-stage multiply/divide unit.
package semimips_pkg;

  // Operation select carried on opin; bit 1 selects divide, bit 0 selects signed.
  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Multiply and divide share one 2*WIDTH accumulator and one iteration counter.
module ex_muldiv
  import semimips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startin,
  input  logic [1:0]       opin,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             mthiin,
  input  logic             mtloin,
  output logic             busyout,
  output logic             doneout,
  output logic             dbzout,
  output logic [WIDTH-1:0] hiout,
  output logic [WIDTH-1:0] loout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e          state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;      // multiplicand for multiply, divisor for divide
  logic               div_op;
  logic               neg_lo;    // negate product (mul) or quotient (div)
  logic               neg_hi;    // negate remainder (signed divide only)
  logic               dbz_pend;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               done;
  logic               dbz;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Operand magnitudes and one shift-add / restoring-divide step.
  always_comb begin
    a_neg   = md_is_signed(opin) & ain[WIDTH-1];
    b_neg   = md_is_signed(opin) & bin[WIDTH-1];
    mag_a   = a_neg ? -ain : ain;
    mag_b   = b_neg ? -bin : bin;

    // Multiply: multiplier sits in the low half and shifts out LSB-first.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Divide: the shifted partial remainder needs WIDTH+1 bits before the trial subtract.
    div_rem  = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, opnd};
    div_next = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign application for the FIX write.
  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    if (div_op) begin
      fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, datapath state and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      div_op   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dbz_pend <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      case (state)
        IDLE: begin
          if (startin) begin
            div_op <= md_is_div(opin);
            if (md_is_div(opin) && (bin == '0)) begin
              // Keep ain so HI receives the dividend at FIX.
              dbz_pend <= 1'b1;
              acc      <= {{WIDTH{1'b0}}, ain};
              state    <= FIX;
            end else begin
              dbz_pend <= 1'b0;
              opnd     <= md_is_div(opin) ? mag_b : mag_a;
              acc      <= {{WIDTH{1'b0}}, (md_is_div(opin) ? mag_a : mag_b)};
              neg_lo   <= a_neg ^ b_neg;
              neg_hi   <= a_neg & md_is_div(opin);
              cnt      <= '0;
              state    <= RUN;
            end
          end else begin
            if (mthiin) hi <= ain;
            if (mtloin) lo <= ain;
          end
        end
        RUN: begin
          acc <= div_op ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (dbz_pend) begin
            hi  <= acc[WIDTH-1:0];
            lo  <= '1;
            dbz <= 1'b1;
          end else begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busyout = (state != IDLE);
  assign doneout = done;
  assign dbzout  = dbz;
  assign hiout   = hi;
  assign loout   = lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv at WIDTH = 32.
module tb_ex_muldiv;
  import semimips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         startin;
  logic [1:0]   opin;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic         mthiin;
  logic         mtloin;
  logic         busyout;
  logic         doneout;
  logic         dbzout;
  logic [W-1:0] hiout;
  logic [W-1:0] loout;

  int errors = 0;
  int checks = 0;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .startin(startin), .opin(opin), .ain(ain), .bin(bin),
    .mthiin(mthiin), .mtloin(mtloin), .busyout(busyout), .doneout(doneout),
    .dbzout(dbzout), .hiout(hiout), .loout(loout)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge of the doneout cycle (or after a timeout).
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busy_cycles, output bit got_done);
    startin = 1'b1; opin = op; ain = a; bin = b;
    @(negedge clk);
    startin = 1'b0;
    busy_cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (doneout) begin
        got_done = 1'b1;
        break;
      end
      if (busyout) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; startin = 1'b0; opin = 2'b00; ain = '0; bin = '0; mthiin = 1'b0; mtloin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busyout, doneout, dbzout} !== 3'b000 || hiout !== '0 || loout !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h, required all zero",
               busyout, doneout, dbzout, hiout, loout);
    end
  endtask

  task automatic test_multu();
    int bc; bit gd;
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, gd);
    checks++;
    if (!gd || bc !== 33) begin
      errors++; $display("FAIL multu_timing: done=%b busy_cycles=%0d, required 1 and 33", gd, bc);
    end
    checks++;
    if (hiout !== 32'hFFFFFFFE || loout !== 32'h00000001 || dbzout !== 1'b0) begin
      errors++; $display("FAIL multu_result: hi=%h lo=%h dbz=%b, required fffffffe 00000001 0", hiout, loout, dbzout);
    end
    @(negedge clk);
    checks++;
    if (doneout !== 1'b0 || busyout !== 1'b0) begin
      errors++; $display("FAIL done_width: done=%b busy=%b one cycle later, required 0 0", doneout, busyout);
    end
  endtask

  task automatic test_mult();
    int bc; bit gd;
    run_op(MD_MULT, 32'hFFFFFFFD, 32'h00000007, bc, gd);
    checks++;
    if (!gd || hiout !== 32'hFFFFFFFF || loout !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mult_signed: done=%b hi=%h lo=%h, required 1 ffffffff ffffffeb", gd, hiout, loout);
    end
    @(negedge clk);
  endtask

  // Back-to-back: each op is started in the previous op's doneout cycle.
  task automatic test_back_to_back();
    int bc; bit gd;
    run_op(MD_MULTU, 32'h00010000, 32'h00010000, bc, gd);
    checks++;
    if (!gd || hiout !== 32'h00000001 || loout !== 32'h00000000) begin
      errors++; $display("FAIL b2b_multu: done=%b hi=%h lo=%h, required 1 00000001 00000000", gd, hiout, loout);
    end
    run_op(MD_DIV, 32'hFFFFFFF9, 32'h00000002, bc, gd);
    checks++;
    if (!gd || bc !== 33 || loout !== 32'hFFFFFFFD || hiout !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_signed: done=%b busy=%0d lo=%h hi=%h, required 1 33 fffffffd ffffffff",
                         gd, bc, loout, hiout);
    end
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, bc, gd);
    checks++;
    if (!gd || loout !== 32'h80000000 || hiout !== 32'h00000000) begin
      errors++; $display("FAIL div_overflow: done=%b lo=%h hi=%h, required 1 80000000 00000000", gd, loout, hiout);
    end
    @(negedge clk);
  endtask

  task automatic test_dbz();
    int bc; bit gd;
    run_op(MD_DIVU, 32'h00000064, 32'h00000000, bc, gd);
    checks++;
    if (!gd || bc !== 1 || dbzout !== 1'b1) begin
      errors++; $display("FAIL dbz_timing: done=%b busy_cycles=%0d dbz=%b, required 1 1 1", gd, bc, dbzout);
    end
    checks++;
    if (hiout !== 32'h00000064 || loout !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL dbz_result: hi=%h lo=%h, required 00000064 ffffffff", hiout, loout);
    end
    @(negedge clk);
    checks++;
    if (dbzout !== 1'b0) begin
      errors++; $display("FAIL dbz_pulse: dbz=%b one cycle later, required 0", dbzout);
    end
  endtask

  task automatic test_ignore_busy();
    bit gd;
    int bc;
    gd = 1'b0;
    startin = 1'b1; opin = MD_MULTU; ain = 32'd5; bin = 32'd6;
    @(negedge clk);
    startin = 1'b0;
    repeat (10) @(negedge clk);
    startin = 1'b1; opin = MD_DIVU; mthiin = 1'b1; ain = 32'hDEAD; bin = 32'd3;
    @(negedge clk);
    startin = 1'b0; mthiin = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (doneout) begin gd = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!gd || hiout !== 32'd0 || loout !== 32'd30) begin
      errors++; $display("FAIL ignore_busy: done=%b hi=%h lo=%h, required 1 00000000 0000001e", gd, hiout, loout);
    end
    @(negedge clk);
    mthiin = 1'b1; ain = 32'h1234;
    @(negedge clk);
    mthiin = 1'b0; ain = 32'h0;
    checks++;
    if (hiout !== 32'h1234 || loout !== 32'd30) begin
      errors++; $display("FAIL mthi: hi=%h lo=%h, required 00001234 0000001e", hiout, loout);
    end
    mthiin = 1'b1; mtloin = 1'b1; ain = 32'h55;
    @(negedge clk);
    mthiin = 1'b0; mtloin = 1'b0;
    checks++;
    if (hiout !== 32'h55 || loout !== 32'h55) begin
      errors++; $display("FAIL mthi_mtlo: hi=%h lo=%h, required 00000055 00000055", hiout, loout);
    end
    // Start together with MTHI: the move is dropped.
    mthiin = 1'b1;
    run_op(MD_MULTU, 32'd2, 32'd3, bc, gd);
    mthiin = 1'b0;
    checks++;
    if (!gd || hiout !== 32'd0 || loout !== 32'd6) begin
      errors++; $display("FAIL start_wins: done=%b hi=%h lo=%h, required 1 00000000 00000006", gd, hiout, loout);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_abort();
    int bc; bit gd; bit saw_done;
    startin = 1'b1; opin = MD_DIVU; ain = 32'd100; bin = 32'd7;
    @(negedge clk);
    startin = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busyout !== 1'b0 || doneout !== 1'b0 || hiout !== '0 || loout !== '0) begin
      errors++; $display("FAIL rst_abort: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busyout, doneout, hiout, loout);
    end
    saw_done = 1'b0;
    repeat (40) begin
      if (doneout || busyout) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL rst_quiet: activity seen after abort=%b, required 0", saw_done);
    end
    run_op(MD_DIVU, 32'd100, 32'd7, bc, gd);
    checks++;
    if (!gd || loout !== 32'd14 || hiout !== 32'd2) begin
      errors++; $display("FAIL divu_after_rst: done=%b lo=%h hi=%h, required 1 0000000e 00000002", gd, loout, hiout);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_back_to_back();
    test_dbz();
    test_ignore_busy();
    test_rst_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It takes the decoded mul/div request and operands leaving that register, computes MULT/MULTU/DIV/DIVU over multiple cycles, and holds results in architectural HI/LO registers. It raises `busyout` so the hazard unit can freeze the front of the pipe while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, default 32: operand, HI and LO width.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `startin`, input, 1: request a mul/div this cycle.
- `opin`, input, 2: operation select. 00 = MULTU, 01 = MULT, 10 = DIVU, 11 = DIV.
- `ain`, input, WIDTH: operand A (dividend or multiplicand); also the data source for MTHI/MTLO.
- `bin`, input, WIDTH: operand B (divisor or multiplier).
- `mthiin`, input, 1: write `ain` to HI.
- `mtloin`, input, 1: write `ain` to LO.
- `busyout`, output, 1: an operation is in flight.
- `doneout`, output, 1: one-cycle pulse; HI/LO have just been updated.
- `dbzout`, output, 1: divide-by-zero flag; pulses together with `doneout`.
- `hiout`, output, WIDTH: HI register.
- `loout`, output, WIDTH: LO register.

Reset and clocking are fixed: one clock, `clk`; reset `rst` is synchronous and active-high. Reset values: `busyout` = 0, `doneout` = 0, `dbzout` = 0, `hiout` = 0, `loout` = 0, FSM in IDLE, iteration counter = 0.

## Operation
FSM states:
- **IDLE**: waiting for a request.
- **RUN**: WIDTH iterations, one per cycle.
- **FIX**: applies signs and writes HI/LO.

Transitions:
- IDLE, `startin`=1, not (divide with `bin`=0): capture |A| and |B| (unsigned operands as-is) and the result sign bits. Counter ← 0. Go to RUN.
- IDLE, `startin`=1, divide with `bin`=0: go directly to FIX with the dbz marker set.
- RUN: one iteration per cycle, counter increments. After the iteration with counter = WIDTH-1, go to FIX.
- FIX: write HI/LO, pulse `doneout`, go to IDLE.

Arithmetic:
- Multiply: radix-2 shift-add on a 2·WIDTH accumulator. Final value gives HI = upper half, LO = lower half.
- Signed multiply: negate the full 2·WIDTH product when A and B signs differ.
- Divide: restoring division on magnitudes. LO = quotient, HI = remainder.
- Signed divide: quotient negated when the signs of A and B differ; remainder takes the sign of A.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000 (wrap), HI = 0.
- Divide by zero: HI ← `ain`, LO ← all ones, `dbzout` = 1 for the done cycle.

HI/LO and `busyout`:
- `busyout` = (state ≠ IDLE), decoded from state.
- HI/LO change only on the FIX edge, or on an MTHI/MTLO edge in IDLE.

Boundary conditions:
- `startin` while busy: ignored; the hazard unit must hold the request.
- `mthiin`/`mtloin` while busy: ignored.
- `startin` together with `mthiin`/`mtloin` in IDLE: the start wins; the move is dropped.
- `mthiin` and `mtloin` together in IDLE: both HI and LO are written.
- `rst` mid-operation: abort immediately, return to reset values. No HI/LO write and no `doneout`.

## Timing
Let E0 be the edge that samples `startin` in IDLE.
- Normal operation: RUN occupies edges E1..E(WIDTH). The FIX edge is E(WIDTH+1).
- `busyout` is high from after E0 until E(WIDTH+1), i.e. WIDTH+1 cycles (33 for WIDTH = 32).
- `doneout` is high for exactly the one cycle after E(WIDTH+1). `hiout`/`loout` are valid in that same cycle.
- Divide by zero: FIX is at E1. `busyout` is high for 1 cycle; `doneout`/`dbzout` are high after E1.
- A new `startin` is accepted in the `doneout` cycle, giving back-to-back operations.
- MTHI/MTLO: the register updates on the sampling edge; the new value is visible the next cycle.

## Structure
- Shared package `semimips_pkg`:
  - op encodings: `MD_MULTU`, `MD_MULT`, `MD_DIVU`, `MD_DIV`;
  - FSM state enum: IDLE, RUN, FIX.
- Single module. No sub-module required: the shift-add and restoring-divide datapaths share one accumulator and one counter.

## Test plan
All cases use WIDTH = 32.
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `busyout` high 33 cycles, then `doneout` one cycle; HI = 0xFFFFFFFE, LO = 0x00000001.
2. MULT 0xFFFFFFFD (-3) × 0x00000007 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
3. DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
4. DIVU 0x64 / 0 -> `doneout` and `dbzout` high after 2 edges; HI = 0x64, LO = 0xFFFFFFFF.
5. Start MULTU 5 × 6; pulse `startin` (DIVU) and `mthiin` at iteration 10 -> both ignored; result HI = 0, LO = 30. Next, in IDLE, `mthiin` with `ain` = 0x1234 -> HI = 0x1234 the next cycle.
6. Start DIVU 100 / 7; assert `rst` at iteration 10 -> `busyout` = 0 next cycle, HI = LO = 0, no `doneout`. Then DIVU 100 / 7 -> LO = 14, HI = 2.
